// File: rtl/adaptive_filter_pkg.sv
// Shared types and constants for the adaptive filter and its transmit-side feeder.
package adaptive_filter_pkg;

   localparam int DATA_WIDTH        = 14;
   localparam int FRACTIONAL_LENGTH = 6;

   typedef logic signed [DATA_WIDTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH] sample_t;

   typedef enum logic [1:0] {FLUSH, SETTLE, RUN} feeder_state_t;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Power-of-two sample FIFO with a first-word view on rd_data_o and a registered occupancy count.
module feeder_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 14
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q,  level_d;
   logic             push_ok, pop_ok;

   assign full_o    = (level_q == (AW+1)'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign level_o   = level_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // A full FIFO refuses a push even when the same cycle pops.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i  && !empty_o;

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // NOTE: the storage array has no reset; the pointers and level define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/filter_feeder.sv
// Buffers upstream samples and issues them to adaptive_filter at a programmable rate,
// flushing the filter through srst whenever its mode changes.
module filter_feeder
   import adaptive_filter_pkg::FRACTIONAL_LENGTH;
   import adaptive_filter_pkg::feeder_state_t;
   import adaptive_filter_pkg::FLUSH;
   import adaptive_filter_pkg::SETTLE;
   import adaptive_filter_pkg::RUN;
   import adaptive_filter_pkg::cnt_width;
#(
   parameter int DATA_WIDTH   = 14,
   parameter int FIFO_DEPTH   = 8,
   parameter int RATE_DIV_W   = 8,
   parameter int FLUSH_CYCLES = 8
) (
   input  logic                                                   clk,
   input  logic                                                   arst_n,
   input  logic [DATA_WIDTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH] s_tdata,
   input  logic                                                   s_tvalid,
   output logic                                                   s_tready,
   input  logic [RATE_DIV_W-1:0]                                  rate_div,
   input  logic                                                   mode_req,
   output logic [DATA_WIDTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH] f_tdata,
   output logic                                                   f_tvalid,
   output logic                                                   f_ctrl,
   output logic                                                   f_srst,
   output logic                                                   busy,
   output logic                                                   underrun,
   output logic [$clog2(FIFO_DEPTH):0]                            fifo_level
);

   localparam int FCW = cnt_width(FLUSH_CYCLES);
   localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);

   feeder_state_t          state_q, state_d;
   logic [FCW-1:0]         flush_cnt_q, flush_cnt_d;
   logic [RATE_DIV_W-1:0]  strobe_cnt_q, strobe_cnt_d;
   logic                   ctrl_q, ctrl_d;
   logic                   tvalid_q, tvalid_d;
   logic                   underrun_q, underrun_d;
   logic                   busy_q;
   logic [DATA_WIDTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH] tdata_q, tdata_d;

   logic                   strobe, pop;
   logic                   fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0]  fifo_rd_data;

   feeder_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .arst_n    (arst_n),
      .push_i    (s_tvalid),
      .wr_data_i (s_tdata),
      .pop_i     (pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (fifo_level)
   );

   assign s_tready = !fifo_full;
   assign strobe   = (strobe_cnt_q >= rate_div);

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned.
   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      strobe_cnt_d = strobe_cnt_q;
      ctrl_d       = ctrl_q;
      tdata_d      = tdata_q;
      tvalid_d     = 1'b0;
      underrun_d   = 1'b0;
      pop          = 1'b0;

      case (state_q)
         FLUSH: begin
            if (flush_cnt_q == '0) state_d = SETTLE;
            else                   flush_cnt_d = flush_cnt_q - 1'b1;
         end
         SETTLE: begin
            strobe_cnt_d = '0;
            state_d      = RUN;
         end
         RUN: begin
            // A mode change wins over a coincident strobe: nothing is issued on that edge.
            if (mode_req != ctrl_q) begin
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_INIT;
               ctrl_d      = mode_req;
            end else if (strobe) begin
               strobe_cnt_d = '0;
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  tvalid_d = 1'b1;
                  tdata_d  = fifo_rd_data;
               end else begin
                  underrun_d = 1'b1;
               end
            end else begin
               strobe_cnt_d = strobe_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q      <= FLUSH;
         flush_cnt_q  <= FLUSH_INIT;
         strobe_cnt_q <= '0;
         ctrl_q       <= 1'b0;
         tdata_q      <= '0;
         tvalid_q     <= 1'b0;
         underrun_q   <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         strobe_cnt_q <= strobe_cnt_d;
         ctrl_q       <= ctrl_d;
         tdata_q      <= tdata_d;
         tvalid_q     <= tvalid_d;
         underrun_q   <= underrun_d;
         busy_q       <= (state_d != RUN);
      end
   end

   assign f_tdata  = tdata_q;
   assign f_tvalid = tvalid_q;
   assign f_ctrl   = ctrl_q;
   assign f_srst   = (state_q == FLUSH);
   assign busy     = busy_q;
   assign underrun = underrun_q;

endmodule
